// File: rtl/memory_arbiter_ctrl.sv
// memory_arbiter_ctrl: shares the single RAM port between instruction fetch and data access.
//   One requester holds the grant until RAM returns ACCESS. Data wins ties, but a
//   starvation counter forces a fetch grant after STARVE_MAX consecutive data grants.
//   Optional LL/SC link tracking is enabled by defining MEMORY_ARBITER_LLSC_EN.
// Ports:
//   CLK, RST                       clock, synchronous active-high reset
//   iREN, iaddr / iload, iwait     instruction fetch request side
//   dREN, dWEN, datomic, daddr,
//   dstore / dload, dwait          data request side (datomic marks LL / SC)
//   ramREN, ramWEN, ramaddr,
//   ramstore / ramload, ramstate   RAM side (ramstate: FREE, BUSY, ACCESS, ERROR)
module memory_arbiter_ctrl #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned STARVE_MAX = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    output logic [DATA_W-1:0] iload,
    output logic              iwait,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic              datomic,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [DATA_W-1:0] dstore,
    output logic [DATA_W-1:0] dload,
    output logic              dwait,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [ADDR_W-1:0] ramaddr,
    output logic [DATA_W-1:0] ramstore,
    input  logic [DATA_W-1:0] ramload,
    input  logic [1:0]        ramstate
);

    localparam int unsigned CNT_W      = $clog2(STARVE_MAX + 1);
    localparam logic [1:0]  RAM_ACCESS = 2'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IGNT = 2'd1,
        DGNT = 2'd2
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] starve_cnt;
    logic [CNT_W-1:0] next_starve;
    logic             data_req;
    logic             starved;
    logic             access;
    logic             sc_fail;

    assign data_req = dREN | dWEN;
    assign access   = (ramstate == RAM_ACCESS);
    // Fetch has waited through STARVE_MAX data grants and must go next.
    assign starved  = iREN && (starve_cnt == CNT_W'(STARVE_MAX));

`ifdef MEMORY_ARBITER_LLSC_EN
    logic              link_valid;
    logic [ADDR_W-1:0] link_addr;
    logic              next_link_valid;
    logic [ADDR_W-1:0] next_link_addr;

    // An SC without a matching live link completes at once without touching RAM.
    assign sc_fail = dWEN && datomic && !(link_valid && (link_addr == daddr));
`else
    logic unused_datomic;

    assign unused_datomic = datomic;
    assign sc_fail        = 1'b0;
`endif

    // State and bookkeeping registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            starve_cnt <= '0;
`ifdef MEMORY_ARBITER_LLSC_EN
            link_valid <= 1'b0;
            link_addr  <= '0;
`endif
        end else begin
            state      <= next_state;
            starve_cnt <= next_starve;
`ifdef MEMORY_ARBITER_LLSC_EN
            link_valid <= next_link_valid;
            link_addr  <= next_link_addr;
`endif
        end
    end

    // Next-state, counter/link updates and port muxing.
    always_comb begin
        next_state  = state;
        next_starve = starve_cnt;
        ramREN      = 1'b0;
        ramWEN      = 1'b0;
        ramaddr     = '0;
        ramstore    = '0;
        iload       = '0;
        dload       = '0;
        iwait       = iREN;
        dwait       = data_req;
`ifdef MEMORY_ARBITER_LLSC_EN
        next_link_valid = link_valid;
        next_link_addr  = link_addr;
`endif
        if (!RST) begin
            case (state)
                IDLE: begin
                    if (data_req && !starved) begin
                        if (sc_fail) begin
                            dwait = 1'b0;
                        end else begin
                            next_state = DGNT;
                        end
                    end else if (iREN) begin
                        next_state = IGNT;
                    end
                end
                IGNT: begin
                    ramREN  = iREN;
                    ramaddr = iaddr;
                    iload   = ramload;
                    if (!iREN) begin
                        next_state = IDLE;
                    end else if (access) begin
                        iwait       = 1'b0;
                        next_state  = IDLE;
                        next_starve = '0;
                    end
                end
                DGNT: begin
                    ramREN   = dREN;
                    ramWEN   = dWEN;
                    ramaddr  = daddr;
                    ramstore = dstore;
                    dload    = ramload;
                    if (!data_req) begin
                        next_state = IDLE;
                    end else if (access) begin
                        dwait      = 1'b0;
                        next_state = IDLE;
                        if (iREN && (starve_cnt < CNT_W'(STARVE_MAX))) begin
                            next_starve = starve_cnt + CNT_W'(1);
                        end
`ifdef MEMORY_ARBITER_LLSC_EN
                        if (dREN && datomic) begin
                            next_link_valid = 1'b1;
                            next_link_addr  = daddr;
                        end else if (dWEN && datomic) begin
                            dload           = DATA_W'(1);
                            next_link_valid = 1'b0;
                        end else if (dWEN && (daddr == link_addr)) begin
                            next_link_valid = 1'b0;
                        end
`endif
                    end
                end
                default: begin
                    next_state = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_memory_arbiter_ctrl.sv
// tb_memory_arbiter_ctrl: directed and randomized checks of memory_arbiter_ctrl.
//   The bench plays the RAM and both requesters; a transaction-level model
//   (pending requests, owner, memory contents, starvation count, link) predicts outputs.
module tb_memory_arbiter_ctrl;

    localparam int unsigned SMAX = 8;
`ifdef MEMORY_ARBITER_LLSC_EN
    localparam bit LLSC = 1'b1;
`else
    localparam bit LLSC = 1'b0;
`endif
    localparam logic [1:0] FREE   = 2'd0;
    localparam logic [1:0] BUSY   = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;
    localparam logic [1:0] ERROR  = 2'd3;
    localparam logic [1:0] OP_RD  = 2'd0;
    localparam logic [1:0] OP_WR  = 2'd1;
    localparam logic [1:0] OP_LL  = 2'd2;
    localparam logic [1:0] OP_SC  = 2'd3;

    typedef struct packed {
        logic [1:0]  kind;
        logic [31:0] addr;
        logic [31:0] data;
    } dop_t;

    logic        CLK = 1'b0;
    logic        RST;
    logic        iREN, dREN, dWEN, datomic;
    logic [31:0] iaddr, daddr, dstore, iload, dload;
    logic        iwait, dwait, ramREN, ramWEN;
    logic [31:0] ramaddr, ramstore, ramload;
    logic [1:0]  ramstate;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] mem [logic [31:0]];
    int          m_starve;
    bit          m_lv;
    logic [31:0] m_la;
    dop_t        dq[$];
    int          grants[$];

    always #5 CLK = ~CLK;

    memory_arbiter_ctrl dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait),
        .dREN(dREN), .dWEN(dWEN), .datomic(datomic), .daddr(daddr),
        .dstore(dstore), .dload(dload), .dwait(dwait),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
        .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate)
    );

    function automatic logic [31:0] rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : (a ^ 32'h5A5A_0000);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push_op(input logic [1:0] k, input logic [31:0] a, input logic [31:0] d);
        dop_t op;
        op.kind = k;
        op.addr = a;
        op.data = d;
        dq.push_back(op);
    endtask

    task automatic model_reset();
        m_starve = 0;
        m_lv     = 1'b0;
        m_la     = 32'h0;
    endtask

    // Serve one fetch (optional) and the queued data ops; nbusy<0 means random RAM delay.
    task automatic run_round(input bit ireq, input logic [31:0] ia, input int nbusy);
        bit          i_pend;
        int          owner;
        int          busy_seen;
        int          cyc;
        bit          d_has, is_rd, is_wr, is_sc, acc, dw_exp;
        dop_t        cur;
        logic [31:0] ld;
        i_pend    = ireq;
        owner     = 0;
        busy_seen = 0;
        cyc       = 0;
        while ((i_pend || dq.size() != 0) && cyc < 400) begin
            cyc++;
            d_has = (dq.size() != 0);
            cur   = d_has ? dq[0] : '0;
            is_rd = d_has && (cur.kind == OP_RD || cur.kind == OP_LL);
            is_wr = d_has && !is_rd;
            is_sc = LLSC && d_has && (cur.kind == OP_SC);
            iREN    = i_pend;
            iaddr   = ia;
            dREN    = is_rd;
            dWEN    = is_wr;
            datomic = d_has && (cur.kind == OP_LL || cur.kind == OP_SC);
            daddr   = cur.addr;
            dstore  = cur.data;
            if (owner == 0) begin
                ramstate = FREE;
                ramload  = $urandom;
                #1;
                chk("idle_ren", 32'(ramREN), 32'd0);
                chk("idle_wen", 32'(ramWEN), 32'd0);
                dw_exp = d_has;
                if (d_has && !(i_pend && m_starve == SMAX)) begin
                    if (is_sc && !(m_lv && m_la == cur.addr)) begin
                        dw_exp = 1'b0;
                        chk("scfail_dload", dload, 32'd0);
                        void'(dq.pop_front());
                    end else begin
                        owner = 2;
                        grants.push_back(2);
                    end
                end else if (i_pend) begin
                    owner = 1;
                    grants.push_back(1);
                end
                chk("idle_iwait", 32'(iwait), 32'(i_pend));
                chk("idle_dwait", 32'(dwait), 32'(dw_exp));
            end else begin
                acc      = (nbusy < 0) ? ($urandom_range(0, 2) != 0) : (busy_seen >= nbusy);
                ramstate = acc ? ACCESS : (($urandom_range(0, 1) == 1) ? BUSY : ERROR);
                ld       = $urandom;
                if (acc && owner == 1) ld = rd(ia);
                if (acc && owner == 2 && is_rd) ld = rd(cur.addr);
                ramload = ld;
                #1;
                if (owner == 1) begin
                    chk("i_ren", 32'(ramREN), 32'd1);
                    chk("i_wen", 32'(ramWEN), 32'd0);
                    chk("i_addr", ramaddr, ia);
                    chk("i_iwait", 32'(iwait), 32'(!acc));
                    chk("i_dwait", 32'(dwait), 32'(d_has));
                    if (acc) begin
                        chk("iload", iload, rd(ia));
                        m_starve = 0;
                        i_pend   = 1'b0;
                        owner    = 0;
                    end
                end else begin
                    chk("d_ren", 32'(ramREN), 32'(is_rd));
                    chk("d_wen", 32'(ramWEN), 32'(is_wr));
                    chk("d_addr", ramaddr, cur.addr);
                    if (is_wr) chk("d_store", ramstore, cur.data);
                    chk("d_dwait", 32'(dwait), 32'(!acc));
                    chk("d_iwait", 32'(iwait), 32'(i_pend));
                    if (acc) begin
                        if (is_rd)      chk("dload_rd", dload, rd(cur.addr));
                        else if (is_sc) chk("dload_sc", dload, 32'd1);
                        else            chk("dload_wr", dload, ld);
                        if (i_pend && m_starve < SMAX) m_starve++;
                        if (is_wr) mem[cur.addr] = cur.data;
                        if (LLSC) begin
                            if (cur.kind == OP_LL) begin
                                m_lv = 1'b1;
                                m_la = cur.addr;
                            end else if (is_sc || (is_wr && cur.addr == m_la)) begin
                                m_lv = 1'b0;
                            end
                        end
                        void'(dq.pop_front());
                        owner = 0;
                    end
                end
                busy_seen = acc ? 0 : busy_seen + 1;
            end
            @(posedge CLK); #1;
        end
        chk("round_left", 32'(dq.size()) + 32'(i_pend), 32'd0);
        iREN     = 1'b0;
        dREN     = 1'b0;
        dWEN     = 1'b0;
        datomic  = 1'b0;
        ramstate = FREE;
    endtask

    initial begin
        // Reset with a pending fetch: RAM stays quiet, fetch stalls.
        RST = 1'b1; iREN = 1'b1; iaddr = 32'h10; dREN = 1'b0; dWEN = 1'b0;
        datomic = 1'b0; daddr = '0; dstore = '0; ramload = '0; ramstate = FREE;
        model_reset();
        repeat (2) begin
            @(posedge CLK); #1;
            chk("rst_ren", 32'(ramREN), 32'd0);
            chk("rst_iwait", 32'(iwait), 32'd1);
            chk("rst_dwait", 32'(dwait), 32'd0);
            chk("rst_iload", iload, 32'd0);
        end
        RST = 1'b0;
        run_round(1'b1, 32'h10, 0);

        // Fetch and data together: data first, then fetch.
        grants.delete();
        push_op(OP_RD, 32'h40, 32'h0);
        run_round(1'b1, 32'h20, 1);
        chk("prio_n", 32'(grants.size()), 32'd2);
        chk("prio_first_data", 32'(grants[0]), 32'd2);
        chk("prio_then_inst", 32'(grants[1]), 32'd1);

        // Ten data reads with fetch pending: ninth grant is the fetch.
        grants.delete();
        for (int k = 0; k < 10; k++) push_op(OP_RD, 32'h80 + 32'(k * 4), 32'h0);
        run_round(1'b1, 32'h30, -1);
        chk("starve_n", 32'(grants.size()), 32'd11);
        chk("starve_9th_inst", 32'(grants[8]), 32'd1);
        chk("starve_8th_data", 32'(grants[7]), 32'd2);

        // LL/SC success, then a second SC on the consumed link.
        push_op(OP_LL, 32'h100, 32'h0);
        push_op(OP_SC, 32'h100, 32'hDEADBEEF);
        push_op(OP_SC, 32'h100, 32'h5555_5555);
        run_round(1'b0, 32'h0, -1);

        // LL, plain store to the same address, then SC.
        push_op(OP_LL, 32'h100, 32'h0);
        push_op(OP_WR, 32'h100, 32'h11);
        push_op(OP_SC, 32'h100, 32'h22);
        run_round(1'b0, 32'h0, -1);
        push_op(OP_RD, 32'h100, 32'h0);
        run_round(1'b0, 32'h0, 0);

        // Request dropped while granted: enables fall in the same cycle.
        dREN = 1'b1; daddr = 32'h44;
        @(posedge CLK); #1;
        ramstate = BUSY; #1;
        chk("drop_ren_before", 32'(ramREN), 32'd1);
        dREN = 1'b0; #1;
        chk("drop_ren_after", 32'(ramREN), 32'd0);
        chk("drop_dwait", 32'(dwait), 32'd0);
        ramstate = FREE;
        @(posedge CLK); #1;

        // Reset in the middle of a busy data write; the link is lost too.
        push_op(OP_LL, 32'h200, 32'h0);
        run_round(1'b0, 32'h0, 0);
        dWEN = 1'b1; daddr = 32'h300; dstore = 32'h1234;
        @(posedge CLK); #1;
        ramstate = BUSY; #1;
        chk("mid_wen_before", 32'(ramWEN), 32'd1);
        RST = 1'b1;
        @(posedge CLK); #1;
        chk("mid_ren", 32'(ramREN), 32'd0);
        chk("mid_wen", 32'(ramWEN), 32'd0);
        RST = 1'b0; dWEN = 1'b0; ramstate = FREE;
        model_reset();
        push_op(OP_SC, 32'h200, 32'h77);
        push_op(OP_RD, 32'h200, 32'h0);
        run_round(1'b0, 32'h0, 0);

        // Randomized rounds.
        for (int r = 0; r < 60; r++) begin
            int n;
            n = $urandom_range(0, 3);
            for (int k = 0; k < n; k++)
                push_op(2'($urandom_range(0, 3)), 32'h100 + 32'($urandom_range(0, 2)) * 32'd4, $urandom);
            run_round(1'($urandom_range(0, 1)), 32'($urandom_range(0, 15)) << 2, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
